// File: rtl/queue_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head output.
// The head word is picked from the storage array by a 2:1 mux tree on rd_ptr.
module queue_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty, push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A pop on a full queue frees the slot the push writes into.
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        overflow_d  = push_i && full && !pop_i;
        underflow_d = pop_i && empty;

        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; a write during reset is simply suppressed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_q <= mem_d;
        end
    end

    // Heap-ordered mux tree: node 1 is the root, nodes DEPTH..2*DEPTH-1 are the slots.
    logic [DATA_WIDTH-1:0] node [1:2*DEPTH-1];

    for (genvar leaf = 0; leaf < DEPTH; leaf++) begin : g_leaf
        assign node[DEPTH+leaf] = mem_q[leaf];
    end

    for (genvar lvl = 0; lvl < ADDR_WIDTH; lvl++) begin : g_level
        for (genvar j = 0; j < (1 << lvl); j++) begin : g_node
            localparam int K = (1 << lvl) + j;
            assign node[K] = rd_ptr_q[ADDR_WIDTH-1-lvl] ? node[2*K+1] : node[2*K];
        end
    end

    assign data_o      = empty ? '0 : node[1];
    assign full_o      = full;
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_queue_fifo.sv
// Self-checking bench for queue_fifo: a reference queue acts as scoreboard for
// every accepted push/pop and predicts flags, count and error pulses each cycle.
module tb_queue_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          push_i = 1'b0;
    logic          pop_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   count_o;
    logic          overflow_o;
    logic          underflow_o;

    int num_checks = 0;
    int num_fails  = 0;

    logic [DW-1:0] sb[$];
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    queue_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .data_o      (data_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every visible output against the scoreboard's view of the queue.
    task automatic checkState(input string tag);
        logic [DW-1:0] head;
        head = (sb.size() == 0) ? '0 : sb[0];
        checkOutput({tag, "_count"}, 32'(count_o), 32'(sb.size()));
        checkOutput({tag, "_full"},  32'(full_o),  32'(sb.size() == DEPTH));
        checkOutput({tag, "_empty"}, 32'(empty_o), 32'(sb.size() == 0));
        checkOutput({tag, "_data"},  32'(data_o),  32'(head));
        checkOutput({tag, "_ovf"},   32'(overflow_o),  32'(exp_ovf));
        checkOutput({tag, "_unf"},   32'(underflow_o), 32'(exp_unf));
    endtask

    // One clock cycle of push/pop; the popped word is checked before the edge.
    task automatic applyStimulus(input logic push, input logic pop, input logic [DW-1:0] data);
        bit is_empty, is_full, pop_ok, push_ok;
        @(negedge clk_i);
        push_i = push;
        pop_i  = pop;
        data_i = data;
        is_empty = (sb.size() == 0);
        is_full  = (sb.size() == DEPTH);
        pop_ok   = pop && !is_empty;
        push_ok  = push && (!is_full || pop_ok);
        if (pop_ok) begin
            checkOutput("pop_data", 32'(data_o), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (push_ok) sb.push_back(data);
        exp_ovf = push && is_full && !pop;
        exp_unf = pop && is_empty;
        @(posedge clk_i);
        #1;
        checkState("cyc");
    endtask

    task automatic applyReset(input int cycles, input logic push, input logic [DW-1:0] data);
        @(negedge clk_i);
        rst_i  = 1'b1;
        push_i = push;
        pop_i  = 1'b0;
        data_i = data;
        repeat (cycles) @(posedge clk_i);
        #1;
        sb.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        checkState("reset");
        @(negedge clk_i);
        rst_i  = 1'b0;
        push_i = 1'b0;
    endtask

    initial begin
        $display("[TB] starting queue_fifo test");
        applyReset(2, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);

        // Fill and drain in order.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h11 + 8'(i));
        checkOutput("fill_full", 32'(full_o), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0);
        checkOutput("drain_empty", 32'(empty_o), 32'd1);

        // Pointer wrap-around across DEPTH-1 -> 0.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'hB0 + 8'(i));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, '0);

        // Full boundary: rejected push, then push+pop while full.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'hC0 + 8'(i));
        applyStimulus(1'b1, 1'b0, 8'hEE);
        checkOutput("ovf_pulse", 32'(overflow_o), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hEF);
        checkOutput("full_swap_count", 32'(count_o), 32'd8);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0);

        // Empty boundary: push+pop on empty queue.
        applyStimulus(1'b1, 1'b1, 8'h5A);
        checkOutput("unf_pulse", 32'(underflow_o), 32'd1);
        checkOutput("unf_head", 32'(data_o), 32'h5A);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, '0);

        // Reset mid-operation with a concurrent push.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h30 + 8'(i));
        applyReset(1, 1'b1, 8'h77);
        checkOutput("midreset_data", 32'(data_o), 32'd0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, '0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
Synchronous circular-buffer queue with first-word-fall-through output. Upstream producers push words. Downstream consumers read the head word and pop it. Storage is a DEPTH-entry register array with write/read pointers and an occupancy counter. The head word is selected from the array by the read pointer through a 2:1 mux tree, so this block is the storage/pointer stage that feeds the queue's mux selection path.

Parameters:
DATA_WIDTH, 8, width of each queued word
DEPTH, 8, number of entries; must be a power of two, >= 2
ADDR_WIDTH, 3, log2(DEPTH); pointer width

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
data_i  input  DATA_WIDTH  word to enqueue
push_i  input  1  enqueue request, sampled on rising edge
pop_i  input  1  dequeue request, sampled on rising edge
data_o  output  DATA_WIDTH  current head word (first-word-fall-through)
full_o  output  1  high when count == DEPTH
empty_o  output  1  high when count == 0
count_o  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow_o  output  1  one-cycle pulse: push rejected because queue was full
underflow_o  output  1  one-cycle pulse: pop rejected because queue was empty

Behaviour:
- Reset (rst_i high at rising edge) clears the following to 0: wr_ptr, rd_ptr, count, overflow_o, underflow_o.
  - empty_o=1, full_o=0, data_o=0 in the cycle after reset.
  - Array contents are not cleared.
  - Reset overrides push_i/pop_i in the same cycle.
  - Reset mid-operation discards all queued words.
- Accepted push: push_i=1 and (not full, or pop also accepted this cycle).
  - Writes data_i to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH; the wrap from DEPTH-1 to 0 is natural overflow of ADDR_WIDTH bits.
- Accepted pop: pop_i=1 and not empty. rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
  - Unchanged when nothing is accepted.
- full_o and empty_o are combinational decodes of the registered count. No other logic feeds them.
- data_o:
  - Equals mem[rd_ptr] when not empty, and is 0 when empty. Combinational from registered state.
  - A word pushed into an empty queue appears on data_o in the cycle after the push edge (1-cycle write-to-read latency).
  - Popped word: the consumer samples data_o in the same cycle it asserts pop_i.
- Simultaneous push and pop:
  - Queue empty: push accepted; pop rejected; underflow_o pulses; count becomes 1.
  - Queue full: both accepted. The new word goes to the slot being freed (wr_ptr == rd_ptr). count stays DEPTH. No overflow.
  - Otherwise: both accepted; count unchanged.
- Error pulses, registered and high for exactly the one cycle after the offending edge:
  - overflow_o is set when push_i=1, the queue is full, and pop_i=0. The rejected word is dropped and state is unchanged.
  - underflow_o is set when pop_i=1 and the queue is empty. State is unchanged apart from any accepted push.
  - Both pulses clear the following cycle unless the condition repeats.
- No X propagation: data_o must not be X after reset, even though the array is uninitialised, because it is forced to 0 while empty.

Test Plan:
- Reset then idle: assert rst_i 2 cycles -> empty_o=1, full_o=0, count_o=0, data_o=0, both error pulses 0.
- Fill and drain: push 0x11..0x18 on 8 consecutive cycles -> full_o=1, count_o=8. Then pop 8 cycles -> data_o reads 0x11..0x18 in order, ending with empty_o=1.
- Wrap-around: push 5, pop 5, push 6 (0xA0..0xA5), pop 6 -> data_o order 0xA0..0xA5 and count_o tracks 6 down to 0. Pointers cross DEPTH-1 -> 0.
- Full boundary:
  - With the queue full, push 0xEE without pop -> overflow_o high for 1 cycle, count_o=8, head word unchanged.
  - Then push 0xEF with pop -> count_o stays 8, and 0xEF becomes the last word drained.
- Empty boundary: on an empty queue, push 0x5A and pop in the same cycle -> underflow_o pulses, count_o=1, next cycle data_o=0x5A.
- Reset mid-operation: with 3 words queued, assert rst_i together with push_i=1 -> next cycle count_o=0, empty_o=1, data_o=0, and the pushed word is not stored.
